// File: rtl/lsl8_seq.sv
// lsl8_seq: sequential logical shift left, one bit per clock, with start/busy/done handshake.
// Reports the last bit shifted out of the MSB and sticky signed overflow for the operation.
module lsl8_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out,
    output logic             c_out,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t         state;
    logic [SHW-1:0] cnt;
    wire            last = cnt == SHW'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            d_out <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (state != SHIFT && start) begin
            d_out <= d_in;
            cnt   <= shamt;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            state <= shamt != '0 ? SHIFT : DONE;
            busy  <= shamt != '0;
            done  <= shamt == '0;
        end else if (state == SHIFT) begin
            d_out <= {d_out[WIDTH-2:0], 1'b0};
            c_out <= d_out[WIDTH-1];
            ovf   <= ovf | (d_out[WIDTH-1] ^ d_out[WIDTH-2]);
            cnt   <= cnt - SHW'(1);
            state <= last ? DONE : SHIFT;
            busy  <= !last;
            done  <= last;
        end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end
    end
endmodule
